// File: rtl/fifo_ctrl_if.sv
// FWFT push/pop handshake plus memory-side controls for fifo_ctrl.
// Optional ovf/udf sticky flags appear when FIFO_CTRL_ERR_FLAGS_EN is defined.
interface fifo_ctrl_if #(
  parameter int ADDRSIZE = 9
);
  logic                wr_en;
  logic                rd_en;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDRSIZE:0]   count;
  logic [ADDRSIZE-1:0] mem_waddr;
  logic [ADDRSIZE-1:0] mem_raddr;
  logic                mem_wclken;
  logic                mem_wfull;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic                ovf;
  logic                udf;

  modport master (
    output wr_en, rd_en,
    input  full, empty, almost_full, almost_empty, count,
    input  mem_waddr, mem_raddr, mem_wclken, mem_wfull,
    input  ovf, udf
  );

  modport slave (
    input  wr_en, rd_en,
    output full, empty, almost_full, almost_empty, count,
    output mem_waddr, mem_raddr, mem_wclken, mem_wfull,
    output ovf, udf
  );
`else
  modport master (
    output wr_en, rd_en,
    input  full, empty, almost_full, almost_empty, count,
    input  mem_waddr, mem_raddr, mem_wclken, mem_wfull
  );

  modport slave (
    input  wr_en, rd_en,
    output full, empty, almost_full, almost_empty, count,
    output mem_waddr, mem_raddr, mem_wclken, mem_wfull
  );
`endif
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the CNN->ELM dual-port feature-map FIFO.
// Define FIFO_CTRL_ERR_FLAGS_EN to add sticky ovf/udf error flags.
module fifo_ctrl #(
  parameter int ADDRSIZE   = 9,
  parameter int AFULL_LVL  = 508,
  parameter int AEMPTY_LVL = 4
) (
  input logic       wclk,
  input logic       wrst,
  fifo_ctrl_if.slave bus
);
  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] DEPTH_C = PW'(1 << ADDRSIZE);
  localparam logic [ADDRSIZE:0] AF_C    = PW'(AFULL_LVL);
  localparam logic [ADDRSIZE:0] AE_C    = PW'(AEMPTY_LVL);

  logic [ADDRSIZE:0] wptr, rptr, cnt;
  logic [ADDRSIZE:0] wptr_nxt, rptr_nxt, cnt_nxt;
  logic full_q, empty_q, af_q, ae_q;
  logic push_ok, pop_ok;

  assign push_ok = bus.wr_en & ~full_q;
  assign pop_ok  = bus.rd_en & ~empty_q;

  // Occupancy is the pointer distance, so wptr - rptr == count by construction.
  always_comb begin
    wptr_nxt = wptr + {{ADDRSIZE{1'b0}}, push_ok};
    rptr_nxt = rptr + {{ADDRSIZE{1'b0}}, pop_ok};
    cnt_nxt  = wptr_nxt - rptr_nxt;
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      cnt     <= cnt_nxt;
      full_q  <= (cnt_nxt == DEPTH_C);
      empty_q <= (cnt_nxt == '0);
      af_q    <= (cnt_nxt >= AF_C);
      ae_q    <= (cnt_nxt <= AE_C);
    end
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = cnt;
  assign bus.mem_waddr    = wptr[ADDRSIZE-1:0];
  assign bus.mem_raddr    = rptr[ADDRSIZE-1:0];
  assign bus.mem_wclken   = bus.wr_en;
  assign bus.mem_wfull    = full_q;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr_en & full_q)  ovf_q <= 1'b1;
      if (bus.rd_en & empty_q) udf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`endif
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Single-clock pointer/flag controller for the dual-port FIFO memory used to buffer 128-bit feature-map words between CNN conv stages and the ELM stage.
- Drives the memory's write address, read address, write-enable and write-inhibit inputs.
- Exposes a first-word-fall-through (FWFT) push/pop handshake with occupancy count and programmable almost-full/almost-empty flags.
- Holds no data; the read data path is memory read data, valid whenever empty=0.

Parameters:
- ADDRSIZE, 9, memory address bits; DEPTH = 1<<ADDRSIZE (512).
- AFULL_LVL, 508, almost_full asserts when count >= AFULL_LVL.
- AEMPTY_LVL, 4, almost_empty asserts when count <= AEMPTY_LVL.

Ports:
- wclk  in  1  sole clock, rising edge.
- wrst  in  1  synchronous, active-high reset.
- wr_en  in  1  push request.
- rd_en  in  1  pop request (acknowledges current head word).
- full  out  1  FIFO holds DEPTH words.
- empty  out  1  FIFO holds 0 words.
- almost_full  out  1  count >= AFULL_LVL.
- almost_empty  out  1  count <= AEMPTY_LVL.
- count  out  ADDRSIZE+1  current occupancy, 0..DEPTH.
- mem_waddr  out  ADDRSIZE  to memory waddr.
- mem_raddr  out  ADDRSIZE  to memory raddr.
- mem_wclken  out  1  to memory wclken; equals wr_en (combinational).
- mem_wfull  out  1  to memory wfull; equals full.

Interface decisions:
- One clock (wclk); reset wrst is synchronous and active-high.

Behaviour:
- Internal pointers wptr and rptr are ADDRSIZE+1 bits. mem_waddr = wptr[ADDRSIZE-1:0]; mem_raddr = rptr[ADDRSIZE-1:0].
- Reset (wrst=1 at a rising edge): wptr=0, rptr=0, count=0, full=0, empty=1, almost_full=0, almost_empty=1. Any wr_en/rd_en in that cycle is ignored; a reset mid-stream discards contents. Memory contents are not cleared.
- Push accepted: push_ok = wr_en & ~full. Pop accepted: pop_ok = rd_en & ~empty. Requests not accepted are silently dropped; pointers and count do not change for them.
- Full decision: the memory already blocks writes via wfull, so a push while full is rejected even if a pop occurs in the same cycle.
- Empty decision: a pop while empty is rejected even if a push occurs in the same cycle; the push is still accepted.
- Per edge:
  - wptr += push_ok; rptr += pop_ok.
  - count += push_ok − pop_ok; push and pop together leave count unchanged.
  - Pointers wrap modulo 2^(ADDRSIZE+1); addresses wrap 511→0 with no special handling.
- All flags are registered and computed from next-state count: full = (count_next == DEPTH), empty = (count_next == 0), plus the two threshold compares. No combinational path from wr_en/rd_en to any flag.
- Latency:
  - Word pushed at edge N: empty falls after edge N; word readable at memory read data in cycle N+1 (asynchronous memory read).
  - Pop at edge M: the next word is presented in cycle M+1.
- Invariant: wptr − rptr == count at all times.

Optional Feature:
- Macro FIFO_CTRL_ERR_FLAGS_EN.
- When defined, adds two outputs, ovf and udf, both 1 bit, both reset to 0:
  - ovf sets on any cycle with wr_en & full.
  - udf sets on any cycle with rd_en & empty.
  - Both are sticky until wrst.
- When undefined, these ports and their logic are absent.
- Core behaviour is identical either way.

Test Plan:
- Reset, then idle → empty=1, almost_empty=1, full=0, count=0, mem_waddr=mem_raddr=0.
- Push 512 consecutive words (rd_en=0) → count=512, full=1, mem_wfull=1. almost_full first asserts after the 508th push. A 513th push leaves count=512 and wptr unchanged (ovf=1 if enabled).
- From full, pop 512 words → data order matches push order; empty=1 after the 512th pop. An extra pop leaves count=0 (udf=1 if enabled).
- Push and pop every cycle for 1000 cycles starting from count=3 → count stays 3; addresses wrap 511→0 at least once; data order preserved.
- Empty FIFO with wr_en=1 and rd_en=1 in the same cycle → push accepted, pop rejected, count=1, empty=0. Full FIFO with both asserted → pop accepted, push rejected, count=511, full=0.
- With count=200, assert wrst for one cycle while wr_en=1 → next cycle count=0, empty=1, pointers 0, error flags cleared.
